// File: rtl/irq_controller12.sv
// Prioritised interrupt controller: synchronised irq lines, edge/level pending,
// per-channel and global enables, nested in-service tracking, req/ack/eoi handshake.
module irq_controller12 #(
  parameter int NUM_IRQ     = 24,
  parameter int WORD        = 12,
  parameter int ID_W        = 5,
  parameter int SYNC_STAGES = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_IRQ-1:0] irq,
  input  logic [3:0]         reg_addr,
  input  logic [WORD-1:0]    reg_wdata,
  input  logic               reg_we,
  output logic [WORD-1:0]    reg_rdata,
  output logic               irq_req,
  output logic [ID_W-1:0]    irq_vec,
  input  logic               irq_ack,
  input  logic               irq_eoi
);
  // state   | meaning
  // S_IDLE  | no request outstanding, looking for a candidate
  // S_REQ   | request presented, vector frozen until ack or withdrawal
  typedef enum logic {S_IDLE, S_REQ} state_t;

  localparam int WB = (WORD > 1) ? $clog2(WORD) : 1;

  logic [SYNC_STAGES-1:0][NUM_IRQ-1:0] r_sync;
  logic [NUM_IRQ-1:0] r_prev, r_en, r_mode, r_latch, r_isr;
  logic               r_gie, r_req;
  logic [ID_W-1:0]    r_vec;
  state_t             r_state;

  logic [NUM_IRQ-1:0] w_s, w_edge, w_pend, w_isr_low, w_below, w_qual;
  logic [NUM_IRQ-1:0] w_en_wm, w_mode_wm, w_pend_wm, w_wbit, w_latch_clr;
  logic [NUM_IRQ-1:0] w_ack_oh, w_eoi_clr;
  logic [3:0]         w_sel_en, w_sel_mode, w_sel_pend;
  logic               w_wr_gie, w_cand_ok, w_frozen_ok, w_ack_ok;
  logic [ID_W-1:0]    w_cand_id, w_isr_id;
  logic [WORD-1:0]    w_rd_en, w_rd_mode, w_rd_pend, w_ctrl, w_stat;

  assign w_s    = r_sync[SYNC_STAGES-1];
  assign w_edge = w_s & ~r_prev;
  assign w_pend = (r_mode & r_latch) | (~r_mode & w_s);

  // Only channels strictly above the highest-priority in-service one may request.
  assign w_isr_low = r_isr & (~r_isr + NUM_IRQ'(1));
  assign w_below   = w_isr_low - NUM_IRQ'(1);
  assign w_qual    = w_pend & r_en & {NUM_IRQ{r_gie}} & w_below;

  assign w_frozen_ok = w_qual[r_vec];
  assign w_ack_ok    = (r_state == S_REQ) && irq_ack && w_frozen_ok;
  assign w_ack_oh    = w_ack_ok ? (NUM_IRQ'(1) << r_vec) : '0;
  assign w_eoi_clr   = irq_eoi ? w_isr_low : '0;
  assign w_wr_gie    = reg_we && (reg_addr == 4'd12);

  always_comb begin
    w_sel_en   = '0;
    w_sel_mode = '0;
    w_sel_pend = '0;
    if (reg_we) begin
      case (reg_addr[3:2])
        2'd0:    w_sel_en[reg_addr[1:0]]   = 1'b1;
        2'd1:    w_sel_mode[reg_addr[1:0]] = 1'b1;
        2'd2:    w_sel_pend[reg_addr[1:0]] = 1'b1;
        default: ;
      endcase
    end
  end

  always_comb begin
    w_en_wm   = '0;
    w_mode_wm = '0;
    w_pend_wm = '0;
    w_wbit    = '0;
    w_rd_en   = '0;
    w_rd_mode = '0;
    w_rd_pend = '0;
    for (int n = 0; n < NUM_IRQ; n++) begin
      w_en_wm[n]   = w_sel_en[2'(n / WORD)];
      w_mode_wm[n] = w_sel_mode[2'(n / WORD)];
      w_pend_wm[n] = w_sel_pend[2'(n / WORD)];
      w_wbit[n]    = reg_wdata[WB'(n % WORD)];
      if (2'(n / WORD) == reg_addr[1:0]) begin
        w_rd_en[WB'(n % WORD)]   = r_en[n];
        w_rd_mode[WB'(n % WORD)] = r_mode[n];
        w_rd_pend[WB'(n % WORD)] = w_pend[n];
      end
    end
  end

  assign w_latch_clr = (w_pend_wm & w_wbit) | w_ack_oh | w_mode_wm;

  always_comb begin
    w_cand_ok = 1'b0;
    w_cand_id = '0;
    w_isr_id  = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (w_qual[i]) begin
        w_cand_ok = 1'b1;
        w_cand_id = ID_W'(i);
      end
      if (r_isr[i]) w_isr_id = ID_W'(i);
    end
  end

  always_comb begin
    w_ctrl             = '0;
    w_ctrl[0]          = r_gie;
    w_stat             = '0;
    w_stat[ID_W-1:0]   = w_isr_id;
    w_stat[WORD-1]     = |r_isr;
    reg_rdata          = '0;
    case (reg_addr[3:2])
      2'd0: reg_rdata = w_rd_en;
      2'd1: reg_rdata = w_rd_mode;
      2'd2: reg_rdata = w_rd_pend;
      default: begin
        if (reg_addr[1:0] == 2'd0)      reg_rdata = w_ctrl;
        else if (reg_addr[1:0] == 2'd1) reg_rdata = w_stat;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync  <= '0;
      r_prev  <= '0;
      r_en    <= '0;
      r_mode  <= '0;
      r_latch <= '0;
      r_isr   <= '0;
      r_gie   <= 1'b0;
    end else begin
      r_sync  <= {r_sync[SYNC_STAGES-2:0], irq};
      r_prev  <= w_s;
      r_en    <= (r_en & ~w_en_wm) | (w_wbit & w_en_wm);
      r_mode  <= (r_mode & ~w_mode_wm) | (w_wbit & w_mode_wm);
      // A fresh edge beats any clear arriving in the same cycle.
      r_latch <= (r_latch & ~w_latch_clr) | (w_edge & r_mode);
      r_isr   <= (r_isr & ~w_eoi_clr) | w_ack_oh;
      if (w_wr_gie) r_gie <= reg_wdata[0];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_req   <= 1'b0;
      r_vec   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_cand_ok) begin
            r_state <= S_REQ;
            r_req   <= 1'b1;
            r_vec   <= w_cand_id;
          end
        end
        S_REQ: begin
          if (!w_frozen_ok || irq_ack) begin
            r_state <= S_IDLE;
            r_req   <= 1'b0;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_req   <= 1'b0;
        end
      endcase
    end
  end

  assign irq_req = r_req;
  assign irq_vec = r_vec;

endmodule
